// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: round-robin or fixed-priority grant feeding
// a one-entry valid/ready output register that also reports the winning channel.
module rr_arb_mux #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 prio_mode,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [SELW-1:0]  last_r;
  logic [NCH-1:0]   grant_s;
  logic [SELW-1:0]  win_s;
  logic [WIDTH-1:0] win_data_s;
  logic             found_s;
  logic             load_en_s;
  logic             xfer_s;
  int               start_s;
  int               idx_s;

  // Arbiter: scan from channel 0 (fixed priority) or last+1 (round-robin), first valid wins.
  always_comb begin
    grant_s    = '0;
    win_s      = '0;
    win_data_s = '0;
    found_s    = 1'b0;
    idx_s      = 0;
    if (prio_mode) begin
      start_s = 0;
    end else begin
      start_s = int'(last_r) + 1;
    end
    for (int k = 0; k < NCH; k++) begin
      idx_s = (start_s + k) % NCH;
      if (!found_s && in_valid[idx_s]) begin
        found_s         = 1'b1;
        grant_s[idx_s]  = 1'b1;
        win_s           = SELW'(idx_s);
        win_data_s      = in_data[idx_s*WIDTH +: WIDTH];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Register may accept when empty or draining this cycle.
  always_comb begin
    load_en_s = !out_valid || out_ready;
    in_ready  = grant_s & {NCH{load_en_s}};
    xfer_s    = |in_ready;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last_r    <= SELW'(NCH - 1);
    end else if (xfer_s) begin
      out_valid <= 1'b1;
      out_data  <= win_data_s;
      out_sel   <= win_s;
      last_r    <= win_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux with a queue-based reference model checked every cycle.
module tb_rr_arb_mux;
  localparam int NCH   = 4;
  localparam int WIDTH = 32;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b1;
  logic                 prio_mode = 1'b0;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready = 1'b0;

  logic [WIDTH-1:0] chd [NCH];
  int  n_chk = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;

  // reference model state
  bit              m_valid = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int              m_sel = 0;
  int              m_last = NCH - 1;

  rr_arb_mux #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn), .prio_mode(prio_mode), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always_comb in_data = {chd[3], chd[2], chd[1], chd[0]};

  function automatic int model_grant(logic [NCH-1:0] v, bit pm, int last);
    int order[$];
    if (pm) begin
      for (int i = 0; i < NCH; i++) order.push_back(i);
    end else begin
      for (int k = 1; k <= NCH; k++) order.push_back((last + k) % NCH);
    end
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // model reset
  always @(negedge resetn) begin
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_last = NCH - 1;
  end

  // model update on each active edge
  always @(posedge clk) begin
    if (resetn) begin
      int g;
      bit load;
      g = model_grant(in_valid, prio_mode, m_last);
      load = !m_valid || out_ready;
      if (load && g >= 0) begin
        m_valid = 1'b1; m_data = chd[g]; m_sel = g; m_last = g;
      end else if (load) begin
        m_valid = 1'b0;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      logic [NCH-1:0] er;
      g = model_grant(in_valid, prio_mode, m_last);
      er = '0;
      if (g >= 0 && (!m_valid || out_ready)) er[g] = 1'b1;
      chk("m_in_ready", 32'(in_ready), 32'(er));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_out_data", out_data, m_data);
      chk("m_out_sel", 32'(out_sel), 32'(m_sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr[6];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    chd[0] = 32'hC0C0_0000; chd[1] = 32'h1111_1111;
    chd[2] = 32'hA5A5_0002; chd[3] = 32'hC3C3_0003;
    #1 resetn = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk_en = 1'b1;
    step();
    resetn = 1'b1;
    // single requester
    in_valid = 4'b0100; out_ready = 1'b1;
    #1 chk("single_ready", 32'(in_ready), 32'h4);
    step();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_sel", 32'(out_sel), 32'd2);
    chk("single_data", out_data, 32'hA5A5_0002);
    // drain to empty
    in_valid = 4'b0000;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_sel", 32'(out_sel), 32'd2);
    chk("drain_data", out_data, 32'hA5A5_0002);
    // park pointer on channel 3, then full round-robin rotation
    in_valid = 4'b1000;
    step();
    chk("park_sel", 32'(out_sel), 32'd3);
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_onehot", 32'($countones(in_ready)), 32'd1);
      step();
      chk("rr_sel", 32'(out_sel), 32'(exp_rr[i]));
    end
    // fixed priority
    prio_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fp_sel", 32'(out_sel), 32'd0);
    end
    in_valid = 4'b1110;
    step();
    chk("fp_drop0_sel", 32'(out_sel), 32'd1);
    chk("fp_drop0_data", out_data, 32'h1111_1111);
    // back-pressure with channels 2,3 waiting in round-robin
    prio_mode = 1'b0; out_ready = 1'b0; in_valid = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sel", 32'(out_sel), 32'd1);
      chk("bp_data", out_data, 32'h1111_1111);
    end
    out_ready = 1'b1;
    step();
    chk("bp_resume_sel", 32'(out_sel), 32'd2);
    chk("bp_resume_data", out_data, 32'hA5A5_0002);
    // reset mid-stream while holding a channel-3 beat
    in_valid = 4'b1000;
    step();
    out_ready = 1'b0;
    chk("pre_rst_sel", 32'(out_sel), 32'd3);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_sel", 32'(out_sel), 32'd0);
    step();
    resetn = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 32'h1);
    step();
    chk("post_rst_sel", 32'(out_sel), 32'd0);
    chk("post_rst_data", out_data, 32'hC0C0_0000);
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
